// File: rtl/rotate_engine.sv
// rotate_engine: sequential tetromino rotation with a wall-kick search and a board-checker handshake.
// Block codes: CYAN=0 BLUE=1 ORANGE=2 YELLOW=3 GREEN=4 MAGENTA=5 RED=6; orientation NORMAL=0 ROT_RIGHT=1 ROT2=2 ROT_LEFT=3.
module rotate_engine #(
    parameter int unsigned COORD_W   = 5,
    parameter int unsigned NUM_CELLS = 4,
    parameter int unsigned NUM_KICKS = 5,
    parameter int unsigned BOARD_W   = 10,
    parameter int unsigned BOARD_H   = 20
) (
    input  logic                           Clk,
    input  logic                           Reset_n,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [2:0]                     block,
    input  logic                           rot_left,
    input  logic [1:0]                     cur_orientation,
    input  logic [NUM_CELLS*COORD_W-1:0]   x_block,
    input  logic [NUM_CELLS*COORD_W-1:0]   y_block,
    output logic                           chk_valid,
    input  logic                           chk_ready,
    output logic [NUM_CELLS*COORD_W-1:0]   chk_x,
    output logic [NUM_CELLS*COORD_W-1:0]   chk_y,
    input  logic                           chk_done,
    input  logic                           chk_hit,
    output logic                           done,
    output logic                           ok,
    output logic [NUM_CELLS*COORD_W-1:0]   rot_xblock,
    output logic [NUM_CELLS*COORD_W-1:0]   rot_yblock,
    output logic [1:0]                     new_orientation,
    output logic [2:0]                     kick_idx
);
    localparam int unsigned CW = NUM_CELLS * COORD_W;
    localparam int unsigned SW = COORD_W + 2;

    localparam logic [2:0] CYAN      = 3'd0;
    localparam logic [2:0] YELLOW    = 3'd3;
    localparam logic [1:0] NORMAL    = 2'd0;
    localparam logic [1:0] ROT_RIGHT = 2'd1;
    localparam logic [1:0] ROT2      = 2'd2;
    localparam logic [1:0] ROT_LEFT  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE, S_ROTATE, S_BOUND, S_ISSUE, S_WAIT, S_NEXT, S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [2:0]           blk_q;
    logic                 left_q;
    logic [1:0]           ori_q;
    logic [CW-1:0]        x_q, y_q;
    logic [2:0]           kick_q, kick_d;
    logic signed [SW-1:0] rx_q [NUM_CELLS];
    logic signed [SW-1:0] ry_q [NUM_CELLS];
    logic signed [SW-1:0] rx_d [NUM_CELLS];
    logic signed [SW-1:0] ry_d [NUM_CELLS];

    logic signed [SW-1:0] cx [NUM_CELLS];
    logic signed [SW-1:0] cy [NUM_CELLS];
    logic signed [SW-1:0] dx_c [NUM_CELLS];
    logic signed [SW-1:0] dy_c [NUM_CELLS];
    logic signed [SW-1:0] px, py, pdx, pdy;

    logic signed [SW-1:0] kx, ky;
    logic signed [SW-1:0] cand_xs [NUM_CELLS];
    logic signed [SW-1:0] cand_ys [NUM_CELLS];
    logic [CW-1:0]        cand_x, cand_y;
    logic                 in_bounds;

    logic                 accept;
    logic                 req_ready_d, chk_valid_d, done_d, ok_d;
    logic [CW-1:0]        chk_x_d, chk_y_d, rot_x_d, rot_y_d;
    logic [1:0]           new_ori_d;
    logic [2:0]           kick_idx_d;

    function automatic logic [1:0] advance(input logic [1:0] o, input logic l);
        return l ? o - 2'd1 : o + 2'd1;
    endfunction

    // Rotation about the pivot in doubled coordinates so I-piece half-cell pivots stay integral
    always_comb begin
        pdx = '0;
        pdy = '0;
        case (ori_q)
            NORMAL:    pdy = SW'(1);
            ROT_RIGHT: pdx = SW'(-1);
            ROT2:      pdy = SW'(-1);
            ROT_LEFT:  pdx = SW'(1);
            default:   ;
        endcase
        for (int k = 0; k < NUM_CELLS; k++) begin
            cx[k] = $signed(SW'(x_q[k*COORD_W +: COORD_W]));
            cy[k] = $signed(SW'(y_q[k*COORD_W +: COORD_W]));
        end
        if (blk_q == CYAN) begin
            px = cx[1] + cx[2] + pdx;
            py = cy[1] + cy[2] + pdy;
        end else begin
            px = cx[1] + cx[1];
            py = cy[1] + cy[1];
        end
        for (int k = 0; k < NUM_CELLS; k++) begin
            dx_c[k] = cx[k] + cx[k] - px;
            dy_c[k] = cy[k] + cy[k] - py;
            rx_d[k] = (left_q ? px + dy_c[k] : px - dy_c[k]) >>> 1;
            ry_d[k] = (left_q ? py - dx_c[k] : py + dx_c[k]) >>> 1;
        end
    end

    // Kick-translated candidate and its board bounds test
    always_comb begin
        kx = '0;
        ky = '0;
        case (kick_q)
            3'd1:    kx = SW'(-1);
            3'd2:    kx = SW'(1);
            3'd3:    ky = SW'(-1);
            3'd4:    kx = SW'(-2);
            default: ;
        endcase
        if (left_q) kx = -kx;
        in_bounds = 1'b1;
        cand_x    = '0;
        cand_y    = '0;
        for (int k = 0; k < NUM_CELLS; k++) begin
            cand_xs[k] = rx_q[k] + kx;
            cand_ys[k] = ry_q[k] + ky;
            if (cand_xs[k][SW-1] || cand_ys[k][SW-1] ||
                cand_xs[k] >= $signed(SW'(BOARD_W)) ||
                cand_ys[k] >= $signed(SW'(BOARD_H)))
                in_bounds = 1'b0;
            cand_x[k*COORD_W +: COORD_W] = cand_xs[k][COORD_W-1:0];
            cand_y[k*COORD_W +: COORD_W] = cand_ys[k][COORD_W-1:0];
        end
    end

    always_comb begin
        state_d     = state_q;
        kick_d      = kick_q;
        accept      = 1'b0;
        chk_valid_d = chk_valid;
        chk_x_d     = chk_x;
        chk_y_d     = chk_y;
        done_d      = 1'b0;
        ok_d        = ok;
        rot_x_d     = rot_xblock;
        rot_y_d     = rot_yblock;
        new_ori_d   = new_orientation;
        kick_idx_d  = kick_idx;
        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready) begin
                    accept = 1'b1;
                    if (block == YELLOW) begin
                        state_d    = S_DONE;
                        done_d     = 1'b1;
                        ok_d       = 1'b1;
                        rot_x_d    = x_block;
                        rot_y_d    = y_block;
                        new_ori_d  = advance(cur_orientation, rot_left);
                        kick_idx_d = '0;
                    end else begin
                        state_d = S_ROTATE;
                    end
                end
            end
            S_ROTATE: begin
                kick_d  = '0;
                state_d = S_BOUND;
            end
            S_BOUND: begin
                if (in_bounds) begin
                    chk_valid_d = 1'b1;
                    chk_x_d     = cand_x;
                    chk_y_d     = cand_y;
                    state_d     = S_ISSUE;
                end else begin
                    state_d = S_NEXT;
                end
            end
            S_ISSUE: begin
                if (chk_valid && chk_ready) begin
                    chk_valid_d = 1'b0;
                    state_d     = S_WAIT;
                end
            end
            S_WAIT: begin
                if (chk_done) begin
                    if (chk_hit) begin
                        state_d = S_NEXT;
                    end else begin
                        state_d    = S_DONE;
                        done_d     = 1'b1;
                        ok_d       = 1'b1;
                        rot_x_d    = chk_x;
                        rot_y_d    = chk_y;
                        new_ori_d  = advance(ori_q, left_q);
                        kick_idx_d = kick_q;
                    end
                end
            end
            S_NEXT: begin
                if (kick_q == 3'(NUM_KICKS - 1)) begin
                    state_d    = S_DONE;
                    done_d     = 1'b1;
                    ok_d       = 1'b0;
                    rot_x_d    = x_q;
                    rot_y_d    = y_q;
                    new_ori_d  = ori_q;
                    kick_idx_d = '0;
                end else begin
                    kick_d  = kick_q + 3'd1;
                    state_d = S_BOUND;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        req_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q         <= S_IDLE;
            kick_q          <= '0;
            blk_q           <= '0;
            left_q          <= 1'b0;
            ori_q           <= NORMAL;
            x_q             <= '0;
            y_q             <= '0;
            for (int k = 0; k < NUM_CELLS; k++) begin
                rx_q[k] <= '0;
                ry_q[k] <= '0;
            end
            req_ready       <= 1'b0;
            chk_valid       <= 1'b0;
            chk_x           <= '0;
            chk_y           <= '0;
            done            <= 1'b0;
            ok              <= 1'b0;
            rot_xblock      <= '0;
            rot_yblock      <= '0;
            new_orientation <= NORMAL;
            kick_idx        <= '0;
        end else begin
            state_q         <= state_d;
            kick_q          <= kick_d;
            req_ready       <= req_ready_d;
            chk_valid       <= chk_valid_d;
            chk_x           <= chk_x_d;
            chk_y           <= chk_y_d;
            done            <= done_d;
            ok              <= ok_d;
            rot_xblock      <= rot_x_d;
            rot_yblock      <= rot_y_d;
            new_orientation <= new_ori_d;
            kick_idx        <= kick_idx_d;
            if (accept) begin
                blk_q  <= block;
                left_q <= rot_left;
                ori_q  <= cur_orientation;
                x_q    <= x_block;
                y_q    <= y_block;
            end
            if (state_q == S_ROTATE) begin
                for (int k = 0; k < NUM_CELLS; k++) begin
                    rx_q[k] <= rx_d[k];
                    ry_q[k] <= ry_d[k];
                end
            end
        end
    end

endmodule

// File: tb/tb_rotate_engine.sv
// tb_rotate_engine: scoreboard bench for rotate_engine with a responsive board-checker model.
module tb_rotate_engine;
    localparam logic [2:0] CYAN    = 3'd0;
    localparam logic [2:0] YELLOW  = 3'd3;
    localparam logic [2:0] MAGENTA = 3'd5;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  block = '0;
    logic        rot_left = 1'b0;
    logic [1:0]  cur_orientation = '0;
    logic [19:0] x_block = '0;
    logic [19:0] y_block = '0;
    logic        chk_valid;
    logic        chk_ready = 1'b0;
    logic [19:0] chk_x, chk_y;
    logic        chk_done = 1'b0;
    logic        chk_hit = 1'b0;
    logic        done, ok;
    logic [19:0] rot_xblock, rot_yblock;
    logic [1:0]  new_orientation;
    logic [2:0]  kick_idx;

    typedef struct packed {
        logic        ok;
        logic [19:0] x;
        logic [19:0] y;
        logic [1:0]  ori;
        logic [2:0]  kick;
    } res_t;

    res_t        exp_q[$];
    res_t        got, e;
    int          errors = 0;
    int          checks = 0;
    int          lat, hs, offers, stable_err, busy_err;
    logic        post_done, post_ok;
    logic [19:0] first_cx, first_cy;
    logic        hit_all = 1'b0;
    int          ready_delay = 0;
    logic        hold_valid = 1'b0;

    rotate_engine dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .block(block), .rot_left(rot_left), .cur_orientation(cur_orientation),
        .x_block(x_block), .y_block(y_block),
        .chk_valid(chk_valid), .chk_ready(chk_ready), .chk_x(chk_x), .chk_y(chk_y),
        .chk_done(chk_done), .chk_hit(chk_hit),
        .done(done), .ok(ok), .rot_xblock(rot_xblock), .rot_yblock(rot_yblock),
        .new_orientation(new_orientation), .kick_idx(kick_idx)
    );

    always #5 Clk = ~Clk;

    function automatic logic [19:0] pk(input int a, input int b, input int c, input int d);
        return {5'(d), 5'(c), 5'(b), 5'(a)};
    endfunction

    // Drives one request and plays the checker until done; results land in globals
    task automatic run_req(input logic [2:0] b, input logic l, input logic [1:0] o,
                           input logic [19:0] xb, input logic [19:0] yb);
        int n, stall;
        logic pend;
        logic [19:0] hx, hy;
        hs = 0; offers = 0; stable_err = 0; busy_err = 0;
        first_cx = '0; first_cy = '0; stall = 0; pend = 1'b0; hx = '0; hy = '0;
        n = 0;
        while (!req_ready && n < 50) begin @(posedge Clk); #1; n++; end
        block = b; rot_left = l; cur_orientation = o; x_block = xb; y_block = yb;
        req_valid = 1'b1;
        chk_ready = (ready_delay == 0);
        chk_done = 1'b0; chk_hit = 1'b0;
        @(posedge Clk); #1;
        if (!hold_valid) req_valid = 1'b0;
        for (lat = 1; lat <= 200; lat++) begin
            if (done) break;
            if (req_ready) busy_err++;
            chk_done = 1'b0; chk_hit = 1'b0;
            if (pend) begin chk_done = 1'b1; chk_hit = hit_all; pend = 1'b0; end
            if (chk_valid) begin
                offers++;
                if (stall > 0 && (chk_x !== hx || chk_y !== hy)) stable_err++;
                hx = chk_x; hy = chk_y;
                if (!chk_ready) begin
                    stall++;
                    if (stall >= ready_delay) chk_ready = 1'b1;
                end
                if (chk_ready) begin
                    if (hs == 0) begin first_cx = chk_x; first_cy = chk_y; end
                    hs++; pend = 1'b1; stall = 0;
                end
            end else begin
                chk_ready = (ready_delay == 0);
            end
            @(posedge Clk); #1;
        end
        req_valid = 1'b0; chk_done = 1'b0; chk_hit = 1'b0;
        if (lat > 200) begin
            checks++; errors++;
            $display("FAIL done_timeout: no done within 200 cycles, required done");
        end
        got = {ok, rot_xblock, rot_yblock, new_orientation, kick_idx};
        @(posedge Clk); #1;
        post_done = done; post_ok = ok;
    endtask

    task automatic test_reset();
        logic [88:0] outs;
        Reset_n = 1'b0;
        #3;
        outs = {req_ready, chk_valid, chk_x, chk_y, done, ok, rot_xblock, rot_yblock,
                new_orientation, kick_idx};
        checks++;
        if (outs !== '0) begin errors++; $display("FAIL reset_outputs: got %h required 0", outs); end
        @(posedge Clk); #1; Reset_n = 1'b1;
        @(posedge Clk); #1;
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b required 1", req_ready); end
    endtask

    task automatic test_magenta_cw();
        exp_q.push_back('{1'b1, pk(4,4,4,5), pk(0,1,2,1), 2'd1, 3'd0});
        run_req(MAGENTA, 1'b0, 2'd0, pk(3,4,5,4), pk(1,1,1,0));
        e = exp_q.pop_front();
        checks++; if (got !== e) begin errors++; $display("FAIL t1_result: got %h required %h", got, e); end
        checks++; if (lat !== 5) begin errors++; $display("FAIL t1_latency: got %0d required 5", lat); end
        checks++; if (hs !== 1) begin errors++; $display("FAIL t1_handshakes: got %0d required 1", hs); end
        checks++; if (post_done !== 1'b0) begin errors++; $display("FAIL t1_done_pulse: got %b required 0", post_done); end
        checks++;
        if ({first_cx, first_cy} !== {pk(4,4,4,5), pk(0,1,2,1)}) begin
            errors++; $display("FAIL t1_candidate: got %h/%h required %h/%h", first_cx, first_cy, pk(4,4,4,5), pk(0,1,2,1));
        end
    endtask

    task automatic test_cyan_cw();
        exp_q.push_back('{1'b1, pk(5,5,5,5), pk(1,2,3,4), 2'd1, 3'd0});
        run_req(CYAN, 1'b0, 2'd0, pk(3,4,5,6), pk(2,2,2,2));
        e = exp_q.pop_front();
        checks++; if (got !== e) begin errors++; $display("FAIL t2_result: got %h required %h", got, e); end
        checks++; if (lat !== 5) begin errors++; $display("FAIL t2_latency: got %0d required 5", lat); end
    endtask

    task automatic test_kicks();
        // right wall: kick 0 out of bounds, kick 1 (-1,0) is the first query
        exp_q.push_back('{1'b1, pk(9,8,7,6), pk(3,3,3,3), 2'd2, 3'd1});
        run_req(CYAN, 1'b0, 2'd1, pk(9,9,9,9), pk(1,2,3,4));
        e = exp_q.pop_front();
        checks++; if (got !== e) begin errors++; $display("FAIL kick_cw_result: got %h required %h", got, e); end
        checks++;
        if ({first_cx, first_cy} !== {pk(9,8,7,6), pk(3,3,3,3)}) begin
            errors++; $display("FAIL kick_cw_first_query: got %h/%h required %h/%h", first_cx, first_cy, pk(9,8,7,6), pk(3,3,3,3));
        end
        checks++; if (hs !== 1) begin errors++; $display("FAIL kick_cw_handshakes: got %0d required 1", hs); end
        // left wall, CCW: kick 1 mirrors to (+1,0)
        exp_q.push_back('{1'b1, pk(0,1,2,3), pk(3,3,3,3), 2'd2, 3'd1});
        run_req(CYAN, 1'b1, 2'd3, pk(0,0,0,0), pk(1,2,3,4));
        e = exp_q.pop_front();
        checks++; if (got !== e) begin errors++; $display("FAIL kick_ccw_result: got %h required %h", got, e); end
        // top edge: every kick leaves a cell at y<0, so nothing reaches the checker
        exp_q.push_back('{1'b0, pk(3,4,5,6), pk(0,0,0,0), 2'd0, 3'd0});
        run_req(CYAN, 1'b0, 2'd0, pk(3,4,5,6), pk(0,0,0,0));
        e = exp_q.pop_front();
        checks++; if (got !== e) begin errors++; $display("FAIL kick_top_result: got %h required %h", got, e); end
        checks++; if (hs !== 0) begin errors++; $display("FAIL kick_top_handshakes: got %0d required 0", hs); end
    endtask

    task automatic test_all_hit();
        hit_all = 1'b1;
        exp_q.push_back('{1'b0, pk(3,4,5,4), pk(1,1,1,0), 2'd0, 3'd0});
        run_req(MAGENTA, 1'b0, 2'd0, pk(3,4,5,4), pk(1,1,1,0));
        hit_all = 1'b0;
        e = exp_q.pop_front();
        checks++; if (got !== e) begin errors++; $display("FAIL t4_result: got %h required %h", got, e); end
        checks++; if (hs !== 4) begin errors++; $display("FAIL t4_handshakes: got %0d required 4", hs); end
        checks++; if (post_ok !== 1'b0) begin errors++; $display("FAIL t4_ok_held: got %b required 0", post_ok); end
    endtask

    task automatic test_yellow();
        exp_q.push_back('{1'b1, pk(4,5,4,5), pk(0,0,1,1), 2'd3, 3'd0});
        run_req(YELLOW, 1'b1, 2'd0, pk(4,5,4,5), pk(0,0,1,1));
        e = exp_q.pop_front();
        checks++; if (got !== e) begin errors++; $display("FAIL t5_result: got %h required %h", got, e); end
        checks++; if (lat !== 1) begin errors++; $display("FAIL t5_latency: got %0d required 1", lat); end
        checks++; if (offers !== 0) begin errors++; $display("FAIL t5_chk_valid: got %0d cycles required 0", offers); end
    endtask

    task automatic test_stall_busy();
        ready_delay = 3; hold_valid = 1'b1;
        exp_q.push_back('{1'b1, pk(4,4,4,5), pk(0,1,2,1), 2'd1, 3'd0});
        run_req(MAGENTA, 1'b0, 2'd0, pk(3,4,5,4), pk(1,1,1,0));
        ready_delay = 0; hold_valid = 1'b0;
        e = exp_q.pop_front();
        checks++; if (got !== e) begin errors++; $display("FAIL stall_result: got %h required %h", got, e); end
        checks++; if (stable_err !== 0) begin errors++; $display("FAIL stall_stable: got %0d changes required 0", stable_err); end
        checks++; if (busy_err !== 0) begin errors++; $display("FAIL busy_ready: got %0d ready cycles required 0", busy_err); end
        checks++; if (lat !== 7) begin errors++; $display("FAIL stall_latency: got %0d required 7", lat); end
    endtask

    task automatic test_back_to_back();
        exp_q.push_back('{1'b1, pk(4,4,4,3), pk(2,1,0,1), 2'd3, 3'd0});
        exp_q.push_back('{1'b1, pk(5,5,5,5), pk(1,2,3,4), 2'd1, 3'd0});
        run_req(MAGENTA, 1'b1, 2'd0, pk(3,4,5,4), pk(1,1,1,0));
        e = exp_q.pop_front();
        checks++; if (got !== e) begin errors++; $display("FAIL b2b_first: got %h required %h", got, e); end
        run_req(CYAN, 1'b0, 2'd0, pk(3,4,5,6), pk(2,2,2,2));
        e = exp_q.pop_front();
        checks++; if (got !== e) begin errors++; $display("FAIL b2b_second: got %h required %h", got, e); end
    endtask

    task automatic test_reset_abort();
        int n, dcnt;
        logic [88:0] outs;
        n = 0;
        while (!req_ready && n < 50) begin @(posedge Clk); #1; n++; end
        block = MAGENTA; rot_left = 1'b0; cur_orientation = 2'd0;
        x_block = pk(3,4,5,4); y_block = pk(1,1,1,0);
        req_valid = 1'b1; chk_ready = 1'b1;
        @(posedge Clk); #1; req_valid = 1'b0;
        n = 0;
        while (!chk_valid && n < 20) begin @(posedge Clk); #1; n++; end
        checks++;
        if (n >= 20) begin errors++; $display("FAIL abort_issue: no chk_valid within 20 cycles, required chk_valid"); end
        @(posedge Clk); #1;
        Reset_n = 1'b0;
        #1;
        outs = {req_ready, chk_valid, chk_x, chk_y, done, ok, rot_xblock, rot_yblock,
                new_orientation, kick_idx};
        checks++;
        if (outs !== '0) begin errors++; $display("FAIL abort_outputs: got %h required 0", outs); end
        @(posedge Clk); #1; Reset_n = 1'b1;
        dcnt = 0;
        for (int i = 0; i < 6; i++) begin
            chk_done = (i < 2); chk_hit = 1'b0;
            @(posedge Clk); #1;
            if (done) dcnt++;
        end
        chk_done = 1'b0;
        checks++;
        if (dcnt !== 0) begin errors++; $display("FAIL abort_stray_done: got %0d done cycles required 0", dcnt); end
        exp_q.push_back('{1'b1, pk(4,4,4,5), pk(0,1,2,1), 2'd1, 3'd0});
        run_req(MAGENTA, 1'b0, 2'd0, pk(3,4,5,4), pk(1,1,1,0));
        e = exp_q.pop_front();
        checks++; if (got !== e) begin errors++; $display("FAIL abort_recover: got %h required %h", got, e); end
    endtask

    initial begin
        test_reset();
        test_magenta_cw();
        test_cyan_cw();
        test_kicks();
        test_all_hit();
        test_yellow();
        test_stall_busy();
        test_back_to_back();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
